// File: rtl/spi_16bit_slave.sv
// SPI mode-3 responder with a 64x8 register file, oversampled on clk.
// Optional `SPI_SLAVE_MISO_OE_EN adds miso_oe and forces miso low while it is deasserted.
module spi_16bit_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEVID       = 8'hE5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
`ifdef SPI_SLAVE_MISO_OE_EN
    output logic       miso_oe,
`endif
    output logic       wr_strobe,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_HOLD} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d, shift_next;
    logic        rw_q, rw_d, mb_q, mb_d;
    logic [5:0]  addr_q, addr_d, addr_inc, rd_addr;
    logic [7:0]  tx_q, tx_d, rd_data;
    logic        miso_q, miso_d;
    logic        busy_q, busy_d;
    logic        seen_q, seen_d;
    logic        strobe_q, strobe_d;
    logic [5:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        done_q, done_d;
    logic        reg_we;
    logic [7:0]  regs_q [64];
`ifdef SPI_SLAVE_MISO_OE_EN
    logic        oe_q, oe_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '1;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b1;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    assign shift_next = {shift_q[6:0], mosi_s};
    assign addr_inc   = addr_q + 6'd1;
    assign rd_addr    = (state_q == ST_CMD) ? shift_next[5:0] : addr_inc;
    assign rd_data    = (rd_addr == 6'd0) ? DEVID : regs_q[rd_addr];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        mb_d      = mb_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        busy_d    = busy_q;
        seen_d    = seen_q;
        strobe_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        reg_we    = 1'b0;
`ifdef SPI_SLAVE_MISO_OE_EN
        oe_d      = oe_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_CMD;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    shift_d = '0;
                    seen_d  = 1'b0;
                    miso_d  = 1'b1;
                end
            end
            ST_CMD: begin
                if (sclk_rise) begin
                    shift_d = shift_next;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = '0;
                        rw_d    = shift_next[7];
                        mb_d    = shift_next[6];
                        addr_d  = shift_next[5:0];
                        if (shift_next[7]) tx_d = rd_data;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (sclk_rise) begin
                    shift_d = shift_next;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d  = '0;
                        seen_d = 1'b1;
                        if (!rw_q) begin
                            strobe_d  = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = shift_next;
                            reg_we    = (addr_q != 6'd0);
                        end
                        if (mb_q) begin
                            addr_d = addr_inc;
                            if (rw_q) tx_d = rd_data;
                        end else begin
                            state_d = ST_HOLD;
                            miso_d  = 1'b1;
                        end
                    end
                end else if (sclk_fall && rw_q) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b1};
`ifdef SPI_SLAVE_MISO_OE_EN
                    oe_d   = 1'b1;
`endif
                end
            end
            default: ;
        endcase
        // Frame close is applied after the byte logic so a coincident final rise still commits.
        if (state_q != ST_IDLE && cs_rise) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = seen_d;
            miso_d  = 1'b1;
`ifdef SPI_SLAVE_MISO_OE_EN
            oe_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            rw_q      <= 1'b0;
            mb_q      <= 1'b0;
            addr_q    <= '0;
            tx_q      <= '1;
            miso_q    <= 1'b1;
            busy_q    <= 1'b0;
            seen_q    <= 1'b0;
            strobe_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            regs_q    <= '{default: '0};
`ifdef SPI_SLAVE_MISO_OE_EN
            oe_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            mb_q      <= mb_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            busy_q    <= busy_d;
            seen_q    <= seen_d;
            strobe_q  <= strobe_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            if (reg_we) regs_q[wr_addr_d] <= wr_data_d;
`ifdef SPI_SLAVE_MISO_OE_EN
            oe_q      <= oe_d;
`endif
        end
    end

`ifdef SPI_SLAVE_MISO_OE_EN
    assign miso    = oe_q & miso_q;
    assign miso_oe = oe_q;
`else
    assign miso    = miso_q;
`endif
    assign wr_strobe  = strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_spi_16bit_slave.sv
// Randomized bench for spi_16bit_slave: a mode-3 master drives frames and a
// register-file model predicts strobes, read data and frame_done.
module tb_spi_16bit_slave;

    localparam int HALF = 5;
    localparam logic [7:0] DEVID = 8'hE5;

    logic       clk = 1'b0;
    logic       rst_n, sclk, cs_n, mosi;
    logic       miso, wr_strobe, busy, frame_done;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
`ifdef SPI_SLAVE_MISO_OE_EN
    logic       miso_oe;
`endif

    always #5 clk = ~clk;

    spi_16bit_slave #(.SYNC_STAGES(2), .DEVID(8'hE5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso),
`ifdef SPI_SLAVE_MISO_OE_EN
        .miso_oe    (miso_oe),
`endif
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [13:0] obs_wr[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (wr_strobe) obs_wr.push_back({wr_addr, wr_data});
        if (frame_done) done_cnt++;
    end

    logic [7:0] ref_regs [64];
    logic [7:0] tx_b [8];
    logic [7:0] rx_b [8];

    task automatic spi_frame(input int nbits);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        check("busy_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = tx_b[i/8][7-(i%8)];
            repeat (HALF) @(negedge clk);
            rx_b[i/8][7-(i%8)] = miso;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (3*HALF) @(negedge clk);
        check("busy_end", {31'd0, busy}, 32'd0);
        check("miso_idle", {31'd0, miso}, 32'd1);
    endtask

    // Predicts the frame from the command byte, then runs and compares it.
    task automatic run_frame(input int nbits);
        logic        rw, mb;
        logic [5:0]  a;
        int          full, eff;
        logic [7:0]  exp_rd [8];
        logic [13:0] exp_wr[$];
        rw   = tx_b[0][7];
        mb   = tx_b[0][6];
        a    = tx_b[0][5:0];
        full = (nbits >= 8) ? (nbits - 8) / 8 : 0;
        eff  = (!mb && full > 1) ? 1 : full;
        for (int k = 0; k < eff; k++) begin
            if (rw) begin
                exp_rd[k] = (a == 6'd0) ? DEVID : ref_regs[a];
            end else begin
                exp_wr.push_back({a, tx_b[k+1]});
                if (a != 6'd0) ref_regs[a] = tx_b[k+1];
            end
            a = a + 6'd1;
        end
        obs_wr.delete();
        done_cnt = 0;
        spi_frame(nbits);
        if (nbits >= 8) check("cmd_miso_high", {24'd0, rx_b[0]}, 32'hFF);
        if (rw)
            for (int k = 0; k < eff; k++)
                check($sformatf("rd_byte%0d", k), {24'd0, rx_b[k+1]}, {24'd0, exp_rd[k]});
        check("wr_count", obs_wr.size(), exp_wr.size());
        for (int k = 0; k < obs_wr.size() && k < exp_wr.size(); k++)
            check($sformatf("wr_addr_data%0d", k), {18'd0, obs_wr[k]}, {18'd0, exp_wr[k]});
        check("frame_done", done_cnt, (eff > 0) ? 1 : 0);
    endtask

    task automatic set_frame(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        tx_b[0] = b0; tx_b[1] = b1; tx_b[2] = b2; tx_b[3] = b3;
    endtask

    initial begin
        int nb, nbits;
        rst_n = 1'b0; sclk = 1'b1; cs_n = 1'b1; mosi = 1'b0;
        for (int i = 0; i < 64; i++) ref_regs[i] = 8'h00;
        for (int i = 0; i < 8; i++) tx_b[i] = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_miso", {31'd0, miso}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_strobe", {31'd0, wr_strobe}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        set_frame(8'h80, 8'h00, 8'h00, 8'h00); run_frame(16);      // DEVID
        set_frame(8'h2D, 8'h08, 8'h00, 8'h00); run_frame(16);      // single write
        set_frame(8'hAD, 8'h00, 8'h00, 8'h00); run_frame(16);      // read back
        set_frame(8'h72, 8'h11, 8'h22, 8'h33); run_frame(32);      // MB write
        set_frame(8'hF2, 8'h00, 8'h00, 8'h00); run_frame(32);      // MB read
        set_frame(8'h7F, 8'hAA, 8'hBB, 8'h00); run_frame(24);      // wrap into 0x00
        set_frame(8'hBF, 8'h00, 8'h00, 8'h00); run_frame(16);
        set_frame(8'h80, 8'h00, 8'h00, 8'h00); run_frame(16);
        set_frame(8'h1E, 8'h3C, 8'h00, 8'h00); run_frame(16);
        set_frame(8'h1E, 8'h55, 8'h00, 8'h00); run_frame(12);      // abort
        set_frame(8'h9E, 8'h00, 8'h00, 8'h00); run_frame(16);
        set_frame(8'h05, 8'h66, 8'h77, 8'h00); run_frame(24);      // HOLD ignores byte 2
        set_frame(8'h85, 8'h00, 8'h00, 8'h00); run_frame(16);
        set_frame(8'h86, 8'h00, 8'h00, 8'h00); run_frame(16);

        for (int n = 0; n < 40; n++) begin
            nb = int'($urandom_range(1, 3));
            for (int k = 0; k <= nb; k++) tx_b[k] = 8'($urandom);
            nbits = 8 * (nb + 1);
            if ($urandom_range(0, 5) == 0) nbits = int'($urandom_range(1, nbits - 1));
            run_frame(nbits);
        end

        // Reset asserted in the middle of a write frame.
        set_frame(8'h2D, 8'h99, 8'h00, 8'h00);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            sclk = 1'b0;
            mosi = tx_b[i/8][7-(i%8)];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_miso", {31'd0, miso}, 32'd1);
        check("midrst_strobe", {31'd0, wr_strobe}, 32'd0);
        check("midrst_done", {31'd0, frame_done}, 32'd0);
        check("midrst_wr_addr", {26'd0, wr_addr}, 32'd0);
        check("midrst_wr_data", {24'd0, wr_data}, 32'd0);
        sclk = 1'b1; cs_n = 1'b1; mosi = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) ref_regs[i] = 8'h00;
        repeat (5) @(negedge clk);
        set_frame(8'hF2, 8'h00, 8'h00, 8'h00); run_frame(32);
        set_frame(8'hAD, 8'h00, 8'h00, 8'h00); run_frame(16);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_16bit_slave.md
Name: spi_16bit_slave

Overview:
- Synthesizable SPI responder, mode 3 (CPOL=1, CPHA=1); the far end of the 16-bit SPI master interface used for the ADXL345 link.
- Decodes the ADXL345-style frame: bit15 R/W (1=read), bit14 MB (multibyte), bits13:8 address, bits7:0 data.
- Holds a 64x8 register file and serves as the loopback target for master bring-up and regression benches.
- Oversamples SCLK, CS_N and MOSI on the system clock; no logic is clocked by SCLK.

Parameters:
- SYNC_STAGES, 2, number of flops in the synchronizer chain for sclk, cs_n and mosi (minimum 2).
- DEVID, 8'hE5, read-only value returned at address 0x00.

Ports:
- clk  in  1  system clock; must run at least 8x the SCLK frequency.
- rst_n  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock; idles high.
- cs_n  in  1  chip select, active low.
- mosi  in  1  serial data from the master.
- miso  out  1  serial data to the master.
- wr_strobe  out  1  one-cycle pulse when a register is written.
- wr_addr  out  6  address of the register being written.
- wr_data  out  8  data being written.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse when a complete frame ends.

Behaviour:
- Reset is asynchronous, active-low:
  - All outputs go to 0, except miso, which goes to 1.
  - Registers 0x01..0x3F clear to 0x00; state goes to IDLE.
- Synchronizers: each input passes SYNC_STAGES flops.
- Edge detection compares the last two synced samples:
  - sclk rising edge: sample mosi.
  - sclk falling edge: shift miso.
  - cs_n falling/rising edge: frame start/end.
  - Latency from a pin edge to internal action is SYNC_STAGES+1 clk cycles.
- States:
  - IDLE: waiting for a cs_n fall.
  - CMD: receiving 8 command bits.
  - DATA: receiving/sending 8 data bits.
  - HOLD: frame complete, further bits ignored.
- IDLE -> CMD on cs_n fall. busy goes high in the same cycle and a 4-bit bit counter clears.
- CMD: mosi is shifted MSB-first on each sclk rise. After the 8th rise:
  - Latch rw, mb and addr; go to DATA.
  - If rw=1, load the tx shift register with reg[addr], or DEVID when addr=0.
- miso in a read:
  - The tx MSB is driven on the next sclk fall and advances one bit per fall.
  - miso is stable through each sclk rise.
- miso outside a read data phase: driven 1 during CMD, HOLD, IDLE and write frames.
- DATA, write (rw=0): after the 8th data rise:
  - Drive wr_addr/wr_data and pulse wr_strobe for 1 cycle.
  - Update reg[addr] in the same cycle.
  - Writes to 0x00 pulse wr_strobe but leave the register unchanged.
- DATA, read (rw=1): after the 8th data rise, if mb=1, reload tx with the next address.
- End of each data byte:
  - mb=1: addr increments with wrap 0x3F -> 0x00, and the state stays in DATA for the next byte.
  - mb=0: go to HOLD.
- Frame end, cs_n rise from any state:
  - Return to IDLE; busy drops 1 cycle after the synced rise.
  - frame_done pulses only if at least one full data byte completed.
- Mid-frame abort (cs_n rise before the first data byte completes): partial bits discarded, no write, no frame_done.
- cs_n rise in the same cycle as an 8th sclk rise: the rise is processed first (the byte completes and commits), then the frame closes.
- sclk edges while cs_n is high are ignored.
- Reset asserted mid-frame: immediate return to reset values, and no strobe is issued.

Optional Feature:
- Macro: SPI_SLAVE_MISO_OE_EN.
- Defined:
  - Adds output port miso_oe (1 bit).
  - miso_oe is 1 only from the first read-data sclk fall until the cs_n rise; 0 otherwise and at reset.
  - miso outputs 0 whenever miso_oe=0, so it can be used in a board-level tristate.
- Undefined:
  - The miso_oe port is absent.
  - miso behaves as described in Behaviour (idle-high).

Test Plan:
- Read DEVID: frame 16'h8000 at SCLK = clk/10 -> miso bits 8..15 = 8'hE5; wr_strobe stays 0; frame_done pulses once.
- Single write then read: write 16'h2D08 (addr 0x2D, data 0x08) -> wr_strobe with wr_addr=0x2D, wr_data=0x08. Then read 16'hAD00 -> miso data = 0x08.
- Multibyte write: 0x72 followed by data bytes 0x11, 0x22, 0x33 (addr 0x32, MB=1) -> three strobes, to 0x32/0x11, 0x33/0x22 and 0x34/0x33. A multibyte read from 0x32 returns the same bytes.
- Wrap and read-only:
  - MB write of 0x7F followed by 0xAA, 0xBB -> reg 0x3F = 0xAA, and a strobe at addr 0x00 with data 0xBB.
  - A later DEVID read still returns 0xE5.
- Abort and reset:
  - cs_n rises after 12 bits of write 16'h1E55 -> no strobe, no frame_done, reg 0x1E unchanged.
  - rst_n asserted mid-frame -> outputs at reset values, busy=0.
